qc_ldpc_stream_encoder: RTL and testbench
=========================================

# qc_ldpc_stream_encoder

Streaming, multi-Z, column-serial QC-LDPC parity generator with ready/valid handshakes on both sides. It accepts one info block (Z bits, zero-extended to MAX_Z) per cycle and fetches that column's M shift values from an external prototype-matrix ROM. Each parity block accumulates as the XOR of the cyclically rotated info blocks. The finished parity is double-buffered so the next codeword can be accumulated while the current M parity blocks drain. The block sits between the info-block source FIFO and the codeword assembler; systematic info bits bypass it.

## Interface
- NUM_Z, 3, number of supported lifting sizes
- Z_VALUES, '{27,54,81}, supported Z per index, each ≤ MAX_Z
- MAX_Z, 81, datapath width
- K_BLKS, 20, info blocks per codeword (≥2)
- M_BLKS, 4, parity blocks per codeword (≥1)
- Derived: SW = $clog2(MAX_Z); EW = SW+1; AW = $clog2(NUM_Z*K_BLKS)

Ports:
- CLK  in  1  clock
- rst  in  1  reset: synchronous, active-low
- z_sel  in  NUM_Z  one-hot Z select; sampled on column-0 acceptance
- in_valid / in_ready  in/out  1  info handshake
- in_data  in  MAX_Z  info block; bits ≥ Z ignored
- rom_addr  out  AW  ROM row address = z_idx*K_BLKS + col
- rom_data  in  M_BLKS*EW  entry j at [j*EW +: EW]; MSB = null flag, low SW bits = shift
- out_valid / out_ready  out/in  1  parity handshake
- out_data  out  MAX_Z  parity block; bits ≥ Z are zero
- out_last  out  1  high on parity block M_BLKS-1
- cfg_err  out  1  sticky configuration error

## Operation
- col counter runs 0..K_BLKS-1 and advances on each in handshake. It wraps to 0 after K_BLKS-1.
- z_idx decode: lowest set bit of z_sel. If z_sel is all-zero, z_idx = NUM_Z-1. A non-one-hot z_sel sets cfg_err.
- At column 0, rom_addr uses the combinationally decoded z_sel. For columns 1..K-1 it uses the registered z_idx.
- Acceptance cycle t: the execute register captures {in_data masked to Z, col, z_idx}. ROM data is valid at t+1.
- Execute, t+1: per j, term_j = rot(info, s_j). rot output bit b = info[(b+s) mod Z] for b < Z, and 0 for b ≥ Z.
  - term_j = 0 if the null flag is set.
  - term_j = 0 if s ≥ Z; this case also sets cfg_err.
  - col 0: acc_j ← term_j (overwrite, no clear cycle needed).
  - Other columns: acc_j ← acc_j ^ term_j.
  - col K-1: obank_j ← acc_j ^ term_j, ob_full ← 1, oidx ← 0. acc is not used again until the next column 0.
- Output: out_valid = ob_full; out_data = obank[oidx]; out_last = (oidx == M_BLKS-1). Each handshake increments oidx. The handshake with out_last clears ob_full.
- in_ready:
  - 1 for col ≠ K-1.
  - For col = K-1: !ob_full || (out_valid && out_ready && out_last). This is a combinational out_ready→in_ready path and is intended.
  - This guarantees the bank is free at the execute edge, so no overflow is possible.
- cfg_err clears only on reset.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_last 0, rom_addr 0, cfg_err 0. Counters, ob_full and the execute valid bit are 0. The acc and obank contents are don't-care but must not be visible.
- Reset mid-codeword: the partial codeword and any pending parity are discarded. The next accepted block is column 0.
- Latency: out_valid rises 2 cycles after the K-th input handshake.
- Throughput: 1 block/cycle sustained while K_BLKS ≥ M_BLKS and out_ready = 1. There are no bubbles between codewords.
- Final output handshake and K-th input acceptance in the same cycle: both occur; the bank reloads at the next edge.

## Structure
- qc_ldpc_pkg holds:
  - functions for SW, EW and AW width derivation;
  - the ROM entry field layout (null bit, shift field);
  - a z-index decode function that returns the index and an error flag.
- Sub-module qc_ldpc_zrot: a combinational variable-Z cyclic rotator (MAX_Z in, shift, Z value in; MAX_Z out, oversize-shift flag). It is instantiated M_BLKS times.
- Everything else is in the top level: the FSM-free counters and the double buffer.

## Test plan
- Z=27 (z_sel=001). All ROM entries are shift 0, non-null. Block i = 1<<i for i = 0..19. Expect 4 output beats of 81'h0FFFFF, out_last on beat 4, and first out_valid exactly 2 cycles after the 20th acceptance.
- Z=81 (z_sel=100). Only the column-0 parity-0 entry is non-null, with shift 5. Block 0 = 1<<5. Expect parity0 = 81'h1 and parities 1..3 = 0. Repeat at Z=27 with in_data bits 80..27 set: those bits must have no effect.
- Backpressure: hold out_ready=0 during codeword 1 output and stream codeword 2. Expect in_ready to be 0 at column 19 until the final out handshake of codeword 1, with column 19 accepted in that same cycle.
- Back-to-back: 5 codewords with random data, in_valid and out_ready held at 1. Expect no in_ready deassertion and parity matching the reference model per codeword, which confirms the column-0 overwrite.
- Errors: shift 30 at Z=27 must contribute 0 and set cfg_err. z_sel=000 must select Z=81 and set cfg_err. cfg_err must stay high until rst.
- Reset after 10 accepted blocks: outputs take their reset values the next cycle. A fresh 20-block codeword must then encode correctly.

Source files
------------

// File: rtl/qc_ldpc_pkg.sv
// Shared constants, prototype-ROM entry layout and z-select decode for the
// column-serial QC-LDPC parity encoder.
package qc_ldpc_pkg;

  localparam int NUM_Z  = 3;
  localparam int MAX_Z  = 81;
  localparam int K_BLKS = 20;
  localparam int M_BLKS = 4;
  localparam int Z_VALUES [NUM_Z] = '{27, 54, 81};

  function automatic int calc_sw(input int max_z);
    return $clog2(max_z);
  endfunction

  function automatic int calc_ew(input int max_z);
    return calc_sw(max_z) + 1;
  endfunction

  function automatic int calc_aw(input int num_z, input int k_blks);
    return $clog2(num_z * k_blks);
  endfunction

  localparam int SW  = calc_sw(MAX_Z);
  localparam int EW  = calc_ew(MAX_Z);
  localparam int AW  = calc_aw(NUM_Z, K_BLKS);
  localparam int CW  = $clog2(K_BLKS);
  localparam int MW  = (M_BLKS > 1) ? $clog2(M_BLKS) : 1;
  localparam int ZIW = (NUM_Z > 1) ? $clog2(NUM_Z) : 1;

  typedef struct packed {
    logic          null_flag;
    logic [SW-1:0] shift;
  } rom_entry_t;

  typedef struct packed {
    logic [ZIW-1:0] idx;
    logic           err;
  } zdec_t;

  // Lowest set bit wins; an all-zero select falls back to the largest Z.
  function automatic zdec_t zdecode(input logic [NUM_Z-1:0] z_sel);
    zdec_t res;
    int    ones;
    res.idx = ZIW'(NUM_Z - 1);
    ones    = 0;
    for (int i = NUM_Z - 1; i >= 0; i--) begin
      if (z_sel[i]) begin
        res.idx = ZIW'(i);
        ones    = ones + 1;
      end
    end
    res.err = (ones != 1);
    return res;
  endfunction

  function automatic logic [SW-1:0] z_value(input logic [ZIW-1:0] idx);
    logic [SW-1:0] z;
    z = SW'(MAX_Z);
    for (int i = 0; i < NUM_Z; i++) begin
      if (idx == ZIW'(i)) begin
        z = SW'(Z_VALUES[i]);
      end
    end
    return z;
  endfunction

  function automatic logic [MAX_Z-1:0] z_mask(input logic [SW-1:0] z);
    logic [MAX_Z-1:0] one;
    one = MAX_Z'(1);
    return (one << z) - one;
  endfunction

endpackage

// File: rtl/qc_ldpc_zrot.sv
// Variable-Z cyclic rotator: out[b] = in[(b+s) mod Z] for b < Z, zero above Z.
module qc_ldpc_zrot
  import qc_ldpc_pkg::*;
(
  input  logic [MAX_Z-1:0] din,
  input  logic [SW-1:0]    shift,
  input  logic [SW-1:0]    z_val,
  output logic [MAX_Z-1:0] dout,
  output logic             oversize
);

  logic [MAX_Z-1:0]   zmask_s;
  logic [2*MAX_Z-1:0] dbl_s;
  logic [2*MAX_Z-1:0] shifted_s;

  // Two copies of the block placed Z apart turn the modulo rotation into a plain right shift
  always_comb begin
    zmask_s   = z_mask(z_val);
    dbl_s     = {{MAX_Z{1'b0}}, din & zmask_s};
    dbl_s     = dbl_s | (dbl_s << z_val);
    shifted_s = dbl_s >> shift;
    oversize  = (shift >= z_val);
    if (oversize) begin
      dout = {MAX_Z{1'b0}};
    end else begin
      dout = shifted_s[MAX_Z-1:0] & zmask_s;
    end
  end

endmodule

// File: rtl/qc_ldpc_stream_encoder.sv
// Streaming column-serial QC-LDPC parity generator with a double-buffered
// parity bank so the next codeword accumulates while the current one drains.
module qc_ldpc_stream_encoder
  import qc_ldpc_pkg::*;
(
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [NUM_Z-1:0]     z_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAX_Z-1:0]     in_data,
  output logic [AW-1:0]        rom_addr,
  input  logic [M_BLKS*EW-1:0] rom_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAX_Z-1:0]     out_data,
  output logic                 out_last,
  output logic                 cfg_err
);

  localparam logic [CW-1:0] COL_LAST  = CW'(K_BLKS - 1);
  localparam logic [MW-1:0] OIDX_LAST = MW'(M_BLKS - 1);
  localparam logic [AW-1:0] K_AW      = AW'(K_BLKS);

  logic [CW-1:0]     col_r;
  logic [ZIW-1:0]    zidx_r;
  logic              ex_valid_r;
  logic [MAX_Z-1:0]  ex_data_r;
  logic [CW-1:0]     ex_col_r;
  logic [ZIW-1:0]    ex_zidx_r;
  logic [MAX_Z-1:0]  acc_r   [M_BLKS];
  logic [MAX_Z-1:0]  obank_r [M_BLKS];
  logic              ob_full_r;
  logic [MW-1:0]     oidx_r;
  logic              cfg_err_r;

  zdec_t             zdec_s;
  logic [ZIW-1:0]    cur_zidx_s;
  logic              in_hs_s;
  logic              out_hs_s;
  logic              ex_last_s;
  logic [SW-1:0]     ex_z_s;
  logic [MAX_Z-1:0]  rot_s  [M_BLKS];
  logic [MAX_Z-1:0]  term_s [M_BLKS];
  logic [M_BLKS-1:0] over_s;
  logic [M_BLKS-1:0] null_s;
  logic              shift_err_s;

  assign ex_z_s  = z_value(ex_zidx_r);
  assign cfg_err = cfg_err_r;

  for (genvar j = 0; j < M_BLKS; j++) begin : g_par
    rom_entry_t ent_s;
    assign ent_s     = rom_entry_t'(rom_data[j*EW +: EW]);
    assign null_s[j] = ent_s.null_flag;

    qc_ldpc_zrot u_rot (
      .din      (ex_data_r),
      .shift    (ent_s.shift),
      .z_val    (ex_z_s),
      .dout     (rot_s[j]),
      .oversize (over_s[j])
    );
  end

  // Handshakes, ROM addressing and the visible face of the output bank
  always_comb begin
    zdec_s     = zdecode(z_sel);
    cur_zidx_s = (col_r == CW'(0)) ? zdec_s.idx : zidx_r;
    out_valid  = ob_full_r;
    out_last   = ob_full_r && (oidx_r == OIDX_LAST);
    out_data   = ob_full_r ? obank_r[oidx_r] : {MAX_Z{1'b0}};
    out_hs_s   = ob_full_r && out_ready;
    // The last column may only enter once the bank is guaranteed free at its execute edge
    in_ready   = (col_r != COL_LAST) || !ob_full_r || (out_hs_s && out_last);
    in_hs_s    = in_valid && in_ready;
    rom_addr   = AW'(cur_zidx_s) * K_AW + AW'(col_r);
  end

  // Per-parity contribution of the column in execute; null and oversize shifts contribute nothing
  always_comb begin
    ex_last_s   = (ex_col_r == COL_LAST);
    shift_err_s = 1'b0;
    for (int j = 0; j < M_BLKS; j++) begin
      term_s[j]   = (null_s[j] || over_s[j]) ? {MAX_Z{1'b0}} : rot_s[j];
      shift_err_s = shift_err_s | (ex_valid_r & ~null_s[j] & over_s[j]);
    end
  end

  // Column counter, z-index latch, execute valid, bank ownership and sticky error
  always_ff @(posedge CLK) begin
    if (!rst) begin
      col_r      <= CW'(0);
      zidx_r     <= ZIW'(0);
      ex_valid_r <= 1'b0;
      ex_col_r   <= CW'(0);
      ex_zidx_r  <= ZIW'(0);
      ob_full_r  <= 1'b0;
      oidx_r     <= MW'(0);
      cfg_err_r  <= 1'b0;
    end else begin
      ex_valid_r <= in_hs_s;
      if (in_hs_s) begin
        col_r     <= (col_r == COL_LAST) ? CW'(0) : col_r + CW'(1);
        ex_col_r  <= col_r;
        ex_zidx_r <= cur_zidx_s;
        zidx_r    <= cur_zidx_s;
      end
      if (ex_valid_r && ex_last_s) begin
        ob_full_r <= 1'b1;
        oidx_r    <= MW'(0);
      end else if (out_hs_s) begin
        if (out_last) begin
          ob_full_r <= 1'b0;
          oidx_r    <= MW'(0);
        end else begin
          oidx_r <= oidx_r + MW'(1);
        end
      end
      cfg_err_r <= cfg_err_r | shift_err_s |
                   (in_hs_s && (col_r == CW'(0)) && zdec_s.err);
    end
  end

  // Datapath registers; their contents are only observed behind ex_valid_r / ob_full_r
  always_ff @(posedge CLK) begin
    if (in_hs_s) begin
      ex_data_r <= in_data & z_mask(z_value(cur_zidx_s));
    end
    if (ex_valid_r) begin
      for (int j = 0; j < M_BLKS; j++) begin
        acc_r[j] <= (ex_col_r == CW'(0)) ? term_s[j] : (acc_r[j] ^ term_s[j]);
        if (ex_last_s) begin
          obank_r[j] <= acc_r[j] ^ term_s[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_qc_ldpc_stream_encoder.sv
// Directed self-checking bench for qc_ldpc_stream_encoder with a registered ROM model.
module tb_qc_ldpc_stream_encoder;
  import qc_ldpc_pkg::*;

  logic                 CLK = 1'b0;
  logic                 rst;
  logic [NUM_Z-1:0]     z_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [MAX_Z-1:0]     in_data;
  logic [AW-1:0]        rom_addr;
  logic [M_BLKS*EW-1:0] rom_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [MAX_Z-1:0]     out_data;
  logic                 out_last;
  logic                 cfg_err;

  always #5 CLK = ~CLK;

  qc_ldpc_stream_encoder dut (
    .CLK       (CLK),
    .rst       (rst),
    .z_sel     (z_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .cfg_err   (cfg_err)
  );

  logic [M_BLKS*EW-1:0] rom_mem [64];

  always_ff @(posedge CLK) rom_data <= rom_mem[rom_addr];

  // Monitor: samples mid-cycle, so every recorded handshake completes at the next rising edge
  int unsigned      cyc = 0;
  int unsigned      last_acc_cyc = 0;
  int unsigned      last_fin_cyc = 0;
  int unsigned      rise_cyc = 0;
  int unsigned      stall_cnt = 0;
  logic             prev_ov = 1'b0;
  logic [MAX_Z-1:0] beat_q [$];
  logic             beat_last_q [$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (rst) begin
      if (in_valid && in_ready) last_acc_cyc <= cyc;
      if (in_valid && !in_ready) stall_cnt <= stall_cnt + 1;
      if (out_valid && out_ready) begin
        beat_q.push_back(out_data);
        beat_last_q.push_back(out_last);
        if (out_last) last_fin_cyc <= cyc;
      end
      if (out_valid && !prev_ov) rise_cyc <= cyc;
    end
    prev_ov <= out_valid;
  end

  int               n_checks = 0;
  int               n_errors = 0;
  int               rd = 0;
  logic [MAX_Z-1:0] cw_blk  [K_BLKS];
  logic [MAX_Z-1:0] exp_par [M_BLKS];
  logic [MAX_Z-1:0] exp_q   [$];

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [MAX_Z-1:0] rnd_blk();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[MAX_Z-1:0];
  endfunction

  function automatic logic [MAX_Z-1:0] ref_rot(input logic [MAX_Z-1:0] d, input int s, input int z);
    logic [MAX_Z-1:0] r;
    r = {MAX_Z{1'b0}};
    for (int b = 0; b < z; b++) r[b] = d[(b + s) % z];
    return r;
  endfunction

  task automatic ref_parity(input int zi);
    int               z;
    logic [EW-1:0]    e;
    logic [MAX_Z-1:0] acc;
    z = Z_VALUES[zi];
    for (int j = 0; j < M_BLKS; j++) begin
      acc = {MAX_Z{1'b0}};
      for (int c = 0; c < K_BLKS; c++) begin
        e = rom_mem[zi*K_BLKS + c][j*EW +: EW];
        if (!e[EW-1] && (int'(e[SW-1:0]) < z)) acc = acc ^ ref_rot(cw_blk[c], int'(e[SW-1:0]), z);
      end
      exp_par[j] = acc;
    end
  endtask

  task automatic rom_set(input int zi, input logic nul, input int sh);
    for (int c = 0; c < K_BLKS; c++)
      for (int j = 0; j < M_BLKS; j++)
        rom_mem[zi*K_BLKS + c][j*EW +: EW] = {nul, SW'(sh)};
  endtask

  // Presents one block and waits (bounded) for its acceptance; in_valid stays high afterwards
  task automatic send_block(input logic [MAX_Z-1:0] d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      done = in_ready;
      tick();
    end
    if (!done) check_val("send_timeout", done, 1);
  endtask

  task automatic send_cw();
    for (int c = 0; c < K_BLKS; c++) send_block(cw_blk[c]);
    in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 300 && beat_q.size() < n; i++) tick();
    check_val("beat_wait", beat_q.size() >= n, 1);
  endtask

  task automatic expect_beats(input string tag);
    wait_beats(rd + M_BLKS);
    for (int j = 0; j < M_BLKS; j++) begin
      check_val({tag, "_data"}, beat_q[rd], exp_par[j]);
      check_val({tag, "_last"}, beat_last_q[rd], (j == M_BLKS - 1));
      rd++;
    end
  endtask

  task automatic set_exp(input logic [MAX_Z-1:0] p0, input logic [MAX_Z-1:0] p1,
                         input logic [MAX_Z-1:0] p2, input logic [MAX_Z-1:0] p3);
    exp_par[0] = p0;
    exp_par[1] = p1;
    exp_par[2] = p2;
    exp_par[3] = p3;
  endtask

  initial begin
    int unsigned stall_base;
    rst       = 1'b0;
    z_sel     = 3'b001;
    in_valid  = 1'b0;
    in_data   = {MAX_Z{1'b0}};
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) rom_mem[i] = {(M_BLKS*EW){1'b0}};
    repeat (3) tick();

    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_rom_addr", rom_addr, 0);
    check_val("rst_cfg_err", cfg_err, 0);
    rst = 1'b1;
    tick();

    // Z=27, all shifts 0: every parity is the XOR of the one-hot blocks
    rom_set(0, 1'b0, 0);
    for (int i = 0; i < K_BLKS; i++) cw_blk[i] = MAX_Z'(1) << i;
    send_cw();
    set_exp(81'h0FFFFF, 81'h0FFFFF, 81'h0FFFFF, 81'h0FFFFF);
    expect_beats("A");
    check_val("A_latency", rise_cyc - last_acc_cyc, 2);

    // Z=81, one live entry with shift 5
    rom_set(2, 1'b1, 0);
    rom_mem[2*K_BLKS][0 +: EW] = {1'b0, SW'(5)};
    z_sel = 3'b100;
    for (int i = 0; i < K_BLKS; i++) cw_blk[i] = rnd_blk();
    cw_blk[0] = MAX_Z'(1) << 5;
    send_cw();
    set_exp(81'h1, 81'h0, 81'h0, 81'h0);
    expect_beats("B81");

    // Same at Z=27 with bits 80..27 set: they must be ignored
    rom_set(0, 1'b1, 0);
    rom_mem[0][0 +: EW] = {1'b0, SW'(5)};
    z_sel = 3'b001;
    for (int i = 0; i < K_BLKS; i++) cw_blk[i] = rnd_blk();
    cw_blk[0] = (MAX_Z'(1) << 5) | ({MAX_Z{1'b1}} << 27);
    send_cw();
    expect_beats("B27");

    // Backpressure: codeword 1 held, codeword 2 stalls at column 19
    rom_set(0, 1'b0, 0);
    out_ready = 1'b0;
    for (int i = 0; i < K_BLKS; i++) cw_blk[i] = MAX_Z'(1) << i;
    send_cw();
    for (int i = 0; i < K_BLKS; i++) cw_blk[i] = MAX_Z'(1) << (i + 1);
    for (int c = 0; c < K_BLKS - 1; c++) send_block(cw_blk[c]);
    in_data = cw_blk[K_BLKS-1];
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_val("C_hold_ready", in_ready, 0);
      check_val("C_hold_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    send_block(cw_blk[K_BLKS-1]);
    in_valid = 1'b0;
    check_val("C_same_cycle", last_acc_cyc, last_fin_cyc);
    set_exp(81'h0FFFFF, 81'h0FFFFF, 81'h0FFFFF, 81'h0FFFFF);
    expect_beats("C1");
    set_exp(81'h1FFFFE, 81'h1FFFFE, 81'h1FFFFE, 81'h1FFFFE);
    expect_beats("C2");

    // Back-to-back: 5 random codewords at Z=54 against the reference model
    for (int c = 0; c < K_BLKS; c++)
      for (int j = 0; j < M_BLKS; j++)
        rom_mem[K_BLKS + c][j*EW +: EW] = {($urandom_range(0, 3) == 0), SW'($urandom_range(0, 53))};
    z_sel      = 3'b010;
    stall_base = stall_cnt;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < K_BLKS; i++) cw_blk[i] = rnd_blk();
      ref_parity(1);
      for (int j = 0; j < M_BLKS; j++) exp_q.push_back(exp_par[j]);
      for (int c = 0; c < K_BLKS; c++) send_block(cw_blk[c]);
    end
    in_valid = 1'b0;
    wait_beats(rd + 5*M_BLKS);
    for (int k = 0; k < 5*M_BLKS; k++) begin
      check_val("D_par", beat_q[rd], exp_q[k]);
      check_val("D_last", beat_last_q[rd], (k % M_BLKS) == (M_BLKS - 1));
      rd++;
    end
    check_val("D_no_stall", stall_cnt - stall_base, 0);
    check_val("D_cfg_err", cfg_err, 0);

    // Shift 30 at Z=27 contributes nothing and latches cfg_err
    rom_set(0, 1'b1, 0);
    rom_mem[0][0 +: EW] = {1'b0, SW'(30)};
    z_sel = 3'b001;
    for (int i = 0; i < K_BLKS; i++) cw_blk[i] = rnd_blk();
    cw_blk[0] = {MAX_Z{1'b1}};
    send_cw();
    set_exp(81'h0, 81'h0, 81'h0, 81'h0);
    expect_beats("E_shift");
    check_val("E_shift_err", cfg_err, 1);
    repeat (5) tick();
    check_val("E_sticky", cfg_err, 1);

    // Reset with a held parity bank and a half-built codeword
    rom_set(0, 1'b0, 0);
    out_ready = 1'b0;
    for (int i = 0; i < K_BLKS; i++) cw_blk[i] = rnd_blk();
    send_cw();
    for (int c = 0; c < 10; c++) send_block(rnd_blk());
    in_valid = 1'b0;
    check_val("F_pre_valid", out_valid, 1);
    rst = 1'b0;
    tick();
    check_val("F_in_ready", in_ready, 1);
    check_val("F_out_valid", out_valid, 0);
    check_val("F_out_data", out_data, 0);
    check_val("F_out_last", out_last, 0);
    check_val("F_cfg_err", cfg_err, 0);
    check_val("F_rom_addr", rom_addr, 0);
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < K_BLKS; i++) cw_blk[i] = MAX_Z'(1) << i;
    send_cw();
    set_exp(81'h0FFFFF, 81'h0FFFFF, 81'h0FFFFF, 81'h0FFFFF);
    expect_beats("F_fresh");
    check_val("F_beat_count", beat_q.size(), rd);

    // z_sel=000 selects Z=81 and flags cfg_err
    rom_set(2, 1'b1, 0);
    rom_mem[2*K_BLKS][EW +: EW] = {1'b0, SW'(0)};
    z_sel = 3'b000;
    tick();
    check_val("E_zsel0_addr", rom_addr, 2*K_BLKS);
    for (int i = 0; i < K_BLKS; i++) cw_blk[i] = rnd_blk();
    cw_blk[0] = MAX_Z'(1) << 80;
    send_cw();
    set_exp(81'h0, MAX_Z'(1) << 80, 81'h0, 81'h0);
    expect_beats("E_zsel0");
    check_val("E_zsel0_err", cfg_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
